// File: rtl/mem_line_burst.sv
// mem_line_burst: turns one cache-line refill or writeback into N single-word mem accesses
module mem_line_burst #(
  parameter int ADDR_LEN      = 11,
  parameter int LINE_ADDR_LEN = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  rd_req,
  input  logic                                  wr_req,
  input  logic [ADDR_LEN-LINE_ADDR_LEN-1:0]     line_addr,
  input  logic [32*(1<<LINE_ADDR_LEN)-1:0]      wr_line,
  output logic [32*(1<<LINE_ADDR_LEN)-1:0]      rd_line,
  output logic                                  gnt,
  output logic                                  busy,
  output logic [ADDR_LEN-1:0]                   mem_addr,
  output logic                                  mem_wr_req,
  output logic [31:0]                           mem_wr_data,
  input  logic [31:0]                           mem_rd_data
);
  localparam int N  = 1 << LINE_ADDR_LEN;
  localparam int LW = ADDR_LEN - LINE_ADDR_LEN;
  localparam logic [LINE_ADDR_LEN:0] LAST = (LINE_ADDR_LEN+1)'(N - 1);
  localparam logic [LINE_ADDR_LEN:0] FULL = (LINE_ADDR_LEN+1)'(N);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state, state_n;
  logic [LINE_ADDR_LEN:0] cnt;
  logic [LW-1:0] line_q;
  logic [32*N-1:0] wr_line_q;
  logic [LINE_ADDR_LEN-1:0] wr_idx, rd_idx;
  assign wr_idx = cnt[LINE_ADDR_LEN-1:0];
  assign rd_idx = LINE_ADDR_LEN'(cnt - 1'b1);
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = wr_req ? WRITE : rd_req ? READ : IDLE;
      WRITE:   state_n = cnt == LAST ? DONE : WRITE;
      READ:    state_n = cnt == FULL ? DONE : READ;
      default: state_n = IDLE;
    endcase
  end
  // cnt freezes on the last burst cycle so mem_addr keeps its final word through DONE/IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      line_q    <= '0;
      wr_line_q <= '0;
      rd_line   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && state_n != IDLE) begin
        cnt       <= '0;
        line_q    <= line_addr;
        wr_line_q <= wr_line;
      end else if ((state == READ || state == WRITE) && state_n == state) begin
        cnt <= cnt + 1'b1;
      end
      if (state == READ && cnt != '0) rd_line[32*rd_idx +: 32] <= mem_rd_data;
    end
  end
  always_comb begin
    gnt         = state == DONE;
    busy        = state != IDLE;
    mem_wr_req  = state == WRITE;
    mem_wr_data = state == WRITE ? wr_line_q[32*wr_idx +: 32] : '0;
    mem_addr    = {line_q, cnt[LINE_ADDR_LEN] ? {LINE_ADDR_LEN{1'b1}} : wr_idx};
  end
endmodule

// File: tb/tb_mem_line_burst.sv
// tb_mem_line_burst: directed table, corner sequences and random bursts against a word-array model
module tb_mem_line_burst;
  logic clk = 0, rst = 1, rd_req = 0, wr_req = 0, load = 1;
  logic [7:0] line_addr = '0;
  logic [255:0] wr_line = '0, rd_line;
  logic gnt, busy, mem_wr_req;
  logic [10:0] mem_addr;
  logic [31:0] mem_wr_data, mem_rd_data;
  logic [31:0] m [2048];
  logic [31:0] init_m [2048];
  logic [31:0] ref_m [2048];
  logic [31:0] pre [16];
  int compared = 0, mismatched = 0;
  typedef struct {
    bit w;
    logic [7:0] la;
    logic [255:0] wl;
    int lat;
    int wc;
    logic [255:0] rl;
  } vec_t;
  vec_t tbl [4];
  always #5 clk = ~clk;
  mem_line_burst dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req), .line_addr(line_addr),
    .wr_line(wr_line), .rd_line(rd_line), .gnt(gnt), .busy(busy), .mem_addr(mem_addr),
    .mem_wr_req(mem_wr_req), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );
  // word memory with 1-cycle read latency; reset clears only the read register
  always @(posedge clk) begin
    if (load) for (int i = 0; i < 2048; i++) m[i] <= init_m[i];
    else if (mem_wr_req) m[mem_addr] <= mem_wr_data;
    mem_rd_data <= rst ? 32'h0 : m[mem_addr];
  end
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [255:0] ref_line(input logic [7:0] la);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = ref_m[{la, 3'(i)}];
    return r;
  endfunction
  task automatic ref_write(input logic [7:0] la, input logic [255:0] wl);
    for (int i = 0; i < 8; i++) ref_m[{la, 3'(i)}] = wl[32*i +: 32];
  endtask
  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction
  // called right after the accepting edge; cycle k is the k-th cycle after it
  task automatic wait_gnt(input logic [10:0] base, input logic [255:0] wl, input bit scr,
                          output int lat, output int wc, output int bad);
    logic [10:0] ea;
    lat = 0; wc = 0; bad = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (scr && k == 3) begin
        line_addr = 8'($urandom);
        wr_line = rand_line();
      end
      ea = base + 11'(k > 8 ? 7 : k - 1);
      if (mem_wr_req) begin
        wc++;
        if (mem_wr_data !== wl[32*(k-1) +: 32]) bad++;
      end
      if (busy !== 1'b1 || mem_addr !== ea) bad++;
      if (gnt) begin
        lat = k;
        break;
      end
    end
  endtask
  task automatic run_burst(input bit w, input logic [7:0] la, input logic [255:0] wl, input bit scr,
                           output int lat, output int wc, output int bad);
    @(negedge clk);
    wr_req = w; rd_req = !w; line_addr = la; wr_line = wl;
    @(posedge clk);
    wait_gnt({la, 3'b0}, wl, scr, lat, wc, bad);
    @(negedge clk);
    wr_req = 0; rd_req = 0;
  endtask
  initial begin
    int lat, wc, bad, gc;
    logic [255:0] l0, l1, wd, wd4, wd5, exp5, last_rd, wl;
    logic [7:0] la;
    bit w;
    pre = '{32'h0f, 32'hf0, 32'h5e, 32'hb6, 32'h79, 32'h20, 32'h4a, 32'h6d,
            32'hab, 32'h7e, 32'hdb, 32'h28, 32'h6b, 32'h2b, 32'h8a, 32'h8b};
    for (int i = 0; i < 2048; i++) init_m[i] = i < 16 ? pre[i] : $urandom;
    ref_m = init_m;
    for (int i = 0; i < 8; i++) begin
      l0[32*i +: 32] = pre[i];
      l1[32*i +: 32] = pre[8+i];
      wd[32*i +: 32] = 32'h100 + i;
      wd4[32*i +: 32] = 32'h300 + i;
      wd5[32*i +: 32] = 32'h200 + i;
      exp5[32*i +: 32] = i < 4 ? 32'h200 + i : pre[i];
    end
    tbl[0] = '{0, 8'd0, '0, 10, 0, l0};
    tbl[1] = '{0, 8'd1, '0, 10, 0, l1};
    tbl[2] = '{1, 8'd1, wd, 9, 8, l1};
    tbl[3] = '{0, 8'd1, '0, 10, 0, wd};
    repeat (3) @(posedge clk);
    @(negedge clk);
    load = 0;
    chk("reset busy", 256'(busy), 0);
    chk("reset gnt", 256'(gnt), 0);
    chk("reset rd_line", rd_line, 0);
    chk("reset mem_addr", 256'(mem_addr), 0);
    chk("reset mem_wr_req", 256'(mem_wr_req), 0);
    chk("reset mem_wr_data", 256'(mem_wr_data), 0);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      run_burst(tbl[i].w, tbl[i].la, tbl[i].wl, 1, lat, wc, bad);
      chk($sformatf("vec%0d latency", i), 256'(lat), 256'(tbl[i].lat));
      chk($sformatf("vec%0d wr_cycles", i), 256'(wc), 256'(tbl[i].wc));
      chk($sformatf("vec%0d addr_seq", i), 256'(bad), 0);
      chk($sformatf("vec%0d rd_line", i), rd_line, tbl[i].rl);
      if (tbl[i].w) ref_write(tbl[i].la, tbl[i].wl);
    end
    // both requests: write first, read follows after one idle cycle
    @(negedge clk);
    wr_req = 1; rd_req = 1; line_addr = 8'd2; wr_line = wd4;
    @(posedge clk);
    wait_gnt(11'd16, wd4, 0, lat, wc, bad);
    chk("prio write latency", 256'(lat), 9);
    chk("prio write cycles", 256'(wc), 8);
    chk("prio write addr_seq", 256'(bad), 0);
    @(negedge clk);
    wr_req = 0;
    chk("prio idle gap", 256'(busy), 0);
    @(posedge clk);
    wait_gnt(11'd16, '0, 0, lat, wc, bad);
    chk("prio read latency", 256'(lat), 10);
    chk("prio read wr_cycles", 256'(wc), 0);
    chk("prio read addr_seq", 256'(bad), 0);
    @(negedge clk);
    rd_req = 0;
    chk("prio read rd_line", rd_line, wd4);
    ref_write(8'd2, wd4);
    // reset on the 4th write cycle
    @(negedge clk);
    wr_req = 1; line_addr = 8'd0; wr_line = wd5;
    @(posedge clk);
    repeat (3) @(negedge clk);
    @(negedge clk);
    rst = 1; wr_req = 0;
    @(negedge clk);
    chk("abort busy", 256'(busy), 0);
    chk("abort gnt", 256'(gnt), 0);
    chk("abort mem_wr_req", 256'(mem_wr_req), 0);
    chk("abort rd_line", rd_line, 0);
    rst = 0;
    for (int i = 0; i < 4; i++) ref_m[i] = wd5[32*i +: 32];
    run_burst(0, 8'd0, '0, 0, lat, wc, bad);
    chk("abort readback", rd_line, exp5);
    // hold rd_req through gnt with line_addr scrambled mid-burst
    run_burst(0, 8'd1, '0, 1, lat, wc, bad);
    chk("hold latency", 256'(lat), 10);
    chk("hold addr_seq", 256'(bad), 0);
    chk("hold rd_line", rd_line, ref_line(8'd1));
    gc = 0;
    repeat (6) begin
      @(negedge clk);
      gc += int'(gnt) + int'(busy);
    end
    chk("hold single gnt", 256'(gc), 0);
    last_rd = ref_line(8'd1);
    for (int n = 0; n < 40; n++) begin
      w = 1'($urandom_range(0, 1));
      la = 8'($urandom);
      wl = rand_line();
      run_burst(w, la, wl, 1, lat, wc, bad);
      chk($sformatf("rnd%0d latency", n), 256'(lat), w ? 9 : 10);
      chk($sformatf("rnd%0d wr_cycles", n), 256'(wc), w ? 8 : 0);
      chk($sformatf("rnd%0d addr_seq", n), 256'(bad), 0);
      if (w) ref_write(la, wl);
      else last_rd = ref_line(la);
      chk($sformatf("rnd%0d rd_line", n), rd_line, last_rd);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
